// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, issues icache word reads and holds one fetched
// instruction in a single-entry buffer for the fetch/decode latch.
module fetch_stage #(
  parameter logic [31:0] PC_INIT = 32'h0000_0000,
  parameter logic [5:0]  HALT_OP = 6'b111111
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        PCWrite,
  input  logic        fdif_stall,
  input  logic        fdif_flush,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        halt_commit,
  input  logic        ihit,
  input  logic [31:0] iload,
  output logic        iREN,
  output logic [31:0] imemaddr,
  output logic [31:0] fdif_instr,
  output logic [31:0] fdif_npc,
  output logic        fdif_valid,
  output logic        fetch_halted
);

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    HALT_SEEN = 2'd1,
    HALTED    = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] npc_q, npc_d;

  logic        accept;
  logic        space;
  logic        fire;
  logic [31:0] pc_plus4;
  logic [31:0] redirect_aligned;

  assign accept           = valid_q & ~fdif_stall;
  assign space            = ~valid_q | accept;
  assign pc_plus4         = pc_q + 32'd4;
  assign redirect_aligned = redirect_pc & ~32'h0000_0003;

  // Gating with nRST keeps the icache idle for the whole reset, not just after the first edge.
  assign iREN = nRST & (state_q == RUN) & PCWrite & space & ~redirect & ~fdif_flush
              & ~halt_commit;
  assign fire = iREN & ihit;

  assign imemaddr     = pc_q;
  assign fdif_instr   = instr_q;
  assign fdif_npc     = npc_q;
  assign fdif_valid   = valid_q;
  assign fetch_halted = (state_q == HALTED);

  // NOTE: every always_comb output gets its hold value first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    instr_d = instr_q;
    npc_d   = npc_q;

    if (halt_commit) begin
      state_d = HALTED;
      valid_d = 1'b0;
    end else if (state_q != HALTED) begin
      if (redirect) begin
        pc_d    = redirect_aligned;
        valid_d = 1'b0;
        state_d = RUN;
      end else if (fdif_flush) begin
        valid_d = 1'b0;
      end else if (fire) begin
        instr_d = iload;
        npc_d   = pc_plus4;
        valid_d = 1'b1;
        pc_d    = pc_plus4;
        if (iload[31:26] == HALT_OP) begin
          state_d = HALT_SEEN;
        end
      end else if (accept) begin
        valid_d = 1'b0;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  // NOTE: the instruction/npc data registers are reset too, so the buffer shows zeros after reset.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= RUN;
      pc_q    <= PC_INIT;
      valid_q <= 1'b0;
      instr_q <= 32'h0;
      npc_q   <= 32'h0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      npc_q   <= npc_d;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: a transaction-level model predicts each cycle's outputs and
// every fetched instruction; a monitor process pops and compares on the falling edge.
module tb_fetch_stage;

  localparam logic [31:0] PC_INIT = 32'h0000_0000;
  localparam logic [5:0]  HALT_OP = 6'b111111;

  logic        CLK;
  logic        nRST;
  logic        PCWrite;
  logic        fdif_stall;
  logic        fdif_flush;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        halt_commit;
  logic        ihit;
  logic [31:0] iload;
  logic        iREN;
  logic [31:0] imemaddr;
  logic [31:0] fdif_instr;
  logic [31:0] fdif_npc;
  logic        fdif_valid;
  logic        fetch_halted;

  fetch_stage #(.PC_INIT(PC_INIT), .HALT_OP(HALT_OP)) dut (
    .CLK(CLK), .nRST(nRST), .PCWrite(PCWrite), .fdif_stall(fdif_stall),
    .fdif_flush(fdif_flush), .redirect(redirect), .redirect_pc(redirect_pc),
    .halt_commit(halt_commit), .ihit(ihit), .iload(iload), .iREN(iREN),
    .imemaddr(imemaddr), .fdif_instr(fdif_instr), .fdif_npc(fdif_npc),
    .fdif_valid(fdif_valid), .fetch_halted(fetch_halted)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  typedef struct {
    logic        iren;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] instr;
    logic [31:0] npc;
    logic        halted;
  } obs_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] npc;
  } fetch_t;

  obs_t   oq[$];
  fetch_t fq[$];

  int checks = 0;
  int fails  = 0;
  int cyc_n  = 0;

  // Reference model: the stage seen as "program counter + one held instruction + halt flags".
  logic [31:0] m_pc;
  logic        m_paused;
  logic        m_halted;
  logic        m_has;
  logic [31:0] m_instr;
  logic [31:0] m_npc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s (cycle %0d): got %h, expected %h", name, cyc_n, act, exp);
    end
  endtask

  task automatic model_reset();
    m_pc     = PC_INIT;
    m_paused = 1'b0;
    m_halted = 1'b0;
    m_has    = 1'b0;
    m_instr  = 32'h0;
    m_npc    = 32'h0;
  endtask

  // One clock cycle of stimulus; expectations are pushed before the edge that consumes them.
  task automatic cyc(input logic rst_v, input logic pcw, input logic stall, input logic flush,
                     input logic redir, input logic [31:0] rpc, input logic hc,
                     input logic hit, input logic [31:0] ld);
    obs_t   o;
    fetch_t f;
    logic   want_fetch;
    @(posedge CLK);
    #1;
    nRST        = rst_v;
    PCWrite     = pcw;
    fdif_stall  = stall;
    fdif_flush  = flush;
    redirect    = redir;
    redirect_pc = rpc;
    halt_commit = hc;
    ihit        = hit;
    iload       = ld;
    cyc_n++;
    if (!rst_v) model_reset();
    want_fetch = rst_v && !m_halted && !m_paused && pcw && !(m_has && stall)
                 && !redir && !flush && !hc;
    o.iren   = want_fetch;
    o.addr   = m_pc;
    o.valid  = m_has;
    o.instr  = m_instr;
    o.npc    = m_npc;
    o.halted = m_halted;
    oq.push_back(o);
    if (rst_v) begin
      if (hc) begin
        m_halted = 1'b1;
        m_has    = 1'b0;
      end else if (!m_halted) begin
        if (redir) begin
          m_pc     = {rpc[31:2], 2'b00};
          m_has    = 1'b0;
          m_paused = 1'b0;
        end else if (flush) begin
          m_has = 1'b0;
        end else if (want_fetch && hit) begin
          m_instr = ld;
          m_npc   = m_pc + 32'd4;
          m_has   = 1'b1;
          m_pc    = m_pc + 32'd4;
          f.instr = ld;
          f.npc   = m_npc;
          fq.push_back(f);
          if (ld[31:26] == HALT_OP) m_paused = 1'b1;
        end else if (m_has && !stall) begin
          m_has = 1'b0;
        end
      end
    end
  endtask

  task automatic run(input logic pcw, input logic stall, input logic hit, input logic [31:0] ld);
    cyc(1'b1, pcw, stall, 1'b0, 1'b0, 32'h0, 1'b0, hit, ld);
  endtask

  task automatic redir_to(input logic [31:0] rpc, input logic hit);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, rpc, 1'b0, hit, $urandom);
  endtask

  function automatic logic [31:0] rnd_instr();
    logic [31:0] w;
    w = $urandom;
    if ($urandom_range(0, 9) == 0) w[31:26] = HALT_OP;
    else if (w[31:26] == HALT_OP) w[31:26] = 6'h00;
    return w;
  endfunction

  // Monitor: compares cycle observations and, one cycle after each fetch handshake, the buffer.
  initial begin
    obs_t   o;
    fetch_t f;
    logic   fire_prev;
    fire_prev = 1'b0;
    forever begin
      @(negedge CLK);
      if (fire_prev) begin
        if (fq.size() == 0) begin
          check("fetch_unexpected", 32'h1, 32'h0);
        end else begin
          f = fq.pop_front();
          if (nRST) begin
            check("fetch_valid", {31'h0, fdif_valid}, 32'h1);
            check("fetch_instr", fdif_instr, f.instr);
            check("fetch_npc", fdif_npc, f.npc);
          end
        end
      end
      fire_prev = iREN & ihit & nRST;
      if (oq.size() > 0) begin
        o = oq.pop_front();
        check("iREN", {31'h0, iREN}, {31'h0, o.iren});
        check("imemaddr", imemaddr, o.addr);
        check("fdif_valid", {31'h0, fdif_valid}, {31'h0, o.valid});
        check("fdif_instr", fdif_instr, o.instr);
        check("fdif_npc", fdif_npc, o.npc);
        check("fetch_halted", {31'h0, fetch_halted}, {31'h0, o.halted});
      end
    end
  end

  initial begin
    nRST = 1'b0; PCWrite = 1'b0; fdif_stall = 1'b0; fdif_flush = 1'b0;
    redirect = 1'b0; redirect_pc = 32'h0; halt_commit = 1'b0; ihit = 1'b0; iload = 32'h0;
    model_reset();

    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h1234_5678);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h1234_5678);

    // Streaming fetch with ihit every cycle.
    for (int i = 0; i < 6; i++) run(1'b1, 1'b0, 1'b1, 32'h0100_0000 + i);

    // Held buffer for three stalled cycles, then release.
    for (int i = 0; i < 3; i++) run(1'b1, 1'b1, 1'b1, 32'h0BAD_0000 + i);
    for (int i = 0; i < 2; i++) run(1'b1, 1'b0, 1'b1, 32'h0200_0000 + i);

    // Redirect with a simultaneous ihit drops the returned word.
    redir_to(32'h0000_0100, 1'b1);
    for (int i = 0; i < 2; i++) run(1'b1, 1'b0, 1'b1, 32'h0300_0000 + i);

    // PC wrap; misaligned target bits are dropped.
    redir_to(32'hFFFF_FFFF, 1'b0);
    for (int i = 0; i < 3; i++) run(1'b1, 1'b0, 1'b1, 32'h0400_0000 + i);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      logic        rd;
      logic [31:0] tgt;
      rd  = ($urandom_range(0, 99) < 6);
      tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
      cyc(1'b1, ($urandom_range(0, 99) < 85), ($urandom_range(0, 99) < 25),
          ($urandom_range(0, 99) < 8), rd, tgt, 1'b0, ($urandom_range(0, 99) < 70),
          rnd_instr());
    end

    // HALT fetched, wrong-path recovery, HALT again, then commit.
    redir_to(32'h0000_0200, 1'b0);
    run(1'b1, 1'b0, 1'b1, 32'hFC00_0000);
    for (int i = 0; i < 3; i++) run(1'b1, 1'b0, 1'b1, 32'h0500_0000 + i);
    redir_to(32'h0000_0040, 1'b0);
    run(1'b1, 1'b0, 1'b1, 32'hFC00_0123);
    for (int i = 0; i < 2; i++) run(1'b1, 1'b0, 1'b1, 32'h0600_0000 + i);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0);
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, 1'b1, ($urandom_range(0, 1) == 1), ($urandom_range(0, 3) == 0),
          ($urandom_range(0, 2) == 0), $urandom, ($urandom_range(0, 4) == 0), 1'b1,
          rnd_instr());
    end

    // Reset out of HALTED, then reset again while a request is outstanding.
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) run(1'b1, 1'b0, 1'b1, 32'h0700_0000 + i);
    run(1'b1, 1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hDEAD_BEEF);
    #1;
    check("rst_iren_now", {31'h0, iREN}, 32'h0);
    check("rst_valid_now", {31'h0, fdif_valid}, 32'h0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hDEAD_BEEF);
    for (int i = 0; i < 3; i++) run(1'b1, 1'b0, 1'b1, 32'h0800_0000 + i);

    for (int i = 0; i < 3; i++) run(1'b0, 1'b0, 1'b0, 32'h0);
    repeat (2) @(negedge CLK);
    #1;
    check("obs_queue_drained", oq.size(), 32'h0);
    check("fetch_queue_drained", fq.size(), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
